// File: rtl/ysyx_25040129_icache_pkg.sv
// Shared definitions for the instruction cache: geometry defaults, AXI response codes,
// FSM state encoding and small helper functions.
package ysyx_25040129_icache_pkg;

  localparam int          LINE_WORDS_DEF = 4;
  localparam int          SETS_DEF       = 16;
  localparam logic [31:0] FLASH_START    = 32'h3000_0000;
  localparam logic [31:0] FLASH_SIZE     = 32'h1000_0000;

  localparam logic [1:0]  RESP_OKAY      = 2'b00;
  localparam logic [1:0]  RESP_SLVERR    = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOOKUP = 3'd1,
    S_REF_AR = 3'd2,
    S_REF_R  = 3'd3,
    S_BYP_AR = 3'd4,
    S_BYP_R  = 3'd5,
    S_RESP   = 3'd6
  } state_e;

  // Unsigned wrap-around makes this a single compare for [base, base+size).
  function automatic logic in_window(input logic [31:0] a, input logic [31:0] base,
                                     input logic [31:0] size);
    return (a - base) < size;
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/ysyx_25040129_icache_if.sv
// AXI4-Lite read channel (AR + R). Handshake: a transfer happens on a rising edge where
// valid and ready are both high; valid never waits on ready, and once valid is raised the
// payload (address or data/response) is held stable until the transfer completes.
interface ysyx_25040129_icache_if;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;

  modport master (output araddr, output arvalid, input arready,
                  input rdata, input rresp, input rvalid, output rready);
  modport slave  (input araddr, input arvalid, output arready,
                  output rdata, output rresp, output rvalid, input rready);
endinterface

// File: rtl/ysyx_25040129_icache_array.sv
// Tag/valid and data storage. Reads are combinational; writes and the flash-clear of all
// valid bits are synchronous. A flash-clear in the same cycle as a valid set wins.
module ysyx_25040129_icache_array #(
  parameter int LINE_WORDS = 4,
  parameter int SETS       = 16,
  parameter int TAG_W      = 24
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush_i,
  input  logic [$clog2(SETS)-1:0]       idx_i,
  input  logic [$clog2(LINE_WORDS)-1:0] rd_word_i,
  output logic                          rd_valid_o,
  output logic [TAG_W-1:0]              rd_tag_o,
  output logic [31:0]                   rd_data_o,
  input  logic                          wr_en_i,
  input  logic [$clog2(LINE_WORDS)-1:0] wr_word_i,
  input  logic [31:0]                   wr_data_i,
  input  logic                          tag_we_i,
  input  logic                          tag_valid_i,
  input  logic [TAG_W-1:0]              tag_i
);

  logic [SETS-1:0]  valid_q;
  logic [TAG_W-1:0] tag_q  [SETS];
  logic [31:0]      data_q [SETS*LINE_WORDS];

  assign rd_valid_o = valid_q[idx_i];
  assign rd_tag_o   = tag_q[idx_i];
  assign rd_data_o  = data_q[{idx_i, rd_word_i}];

  // Valid bits: reset and flush clear everything; a tag write sets the line's valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
    end else begin
      if (tag_we_i) valid_q[idx_i] <= tag_valid_i;
      if (flush_i)  valid_q <= '0;
    end
  end

  // Tag storage, written on the last refill beat.
  always_ff @(posedge clk) begin
    if (tag_we_i) tag_q[idx_i] <= tag_i;
  end

  // Data storage, one word per refill beat.
  always_ff @(posedge clk) begin
    if (wr_en_i) data_q[{idx_i, wr_word_i}] <= wr_data_i;
  end

endmodule

// File: rtl/ysyx_25040129_icache.sv
// Direct-mapped read-only instruction cache: hit path, line refill, uncached bypass,
// fence.i invalidation and saturating hit/miss counters.
module ysyx_25040129_icache
  import ysyx_25040129_icache_pkg::*;
#(
  parameter int          LINE_WORDS = LINE_WORDS_DEF,
  parameter int          SETS       = SETS_DEF,
  parameter logic [31:0] CACHE_BASE = FLASH_START,
  parameter logic [31:0] CACHE_SIZE = FLASH_SIZE
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          fence_i,
  ysyx_25040129_icache_if.slave         ifu,
  ysyx_25040129_icache_if.master        mem,
  output logic [31:0]                   hit_cnt,
  output logic [31:0]                   miss_cnt,
  output state_e                        state_o
);

  localparam int WB = $clog2(LINE_WORDS);
  localparam int IB = $clog2(SETS);
  localparam int TW = 32 - 2 - WB - IB;

  state_e        state_q, state_d;
  logic [31:2]   addr_q, addr_d;
  logic [WB-1:0] beat_q, beat_d;
  logic          err_q, err_d, kill_q, kill_d;
  logic [31:0]   rdata_q, rdata_d;
  logic [1:0]    rresp_q, rresp_d;
  logic [31:0]   hit_q, hit_d, miss_q, miss_d;

  logic          arr_valid, arr_we, tag_we, tag_valid;
  logic [TW-1:0] arr_tag;
  logic [31:0]   arr_data;
  logic          cacheable, hit, last_beat;
  logic          unused_addr_lsb;

  wire [WB-1:0] req_word = addr_q[2 +: WB];
  wire [IB-1:0] req_idx  = addr_q[2+WB +: IB];
  wire [TW-1:0] req_tag  = addr_q[31 -: TW];

  assign unused_addr_lsb = ^ifu.araddr[1:0];
  assign cacheable = in_window({addr_q, 2'b00}, CACHE_BASE, CACHE_SIZE);
  assign hit       = cacheable && arr_valid && (arr_tag == req_tag);
  assign last_beat = (beat_q == WB'(LINE_WORDS - 1));
  assign hit_cnt   = hit_q;
  assign miss_cnt  = miss_q;
  assign state_o   = state_q;

  ysyx_25040129_icache_array #(
    .LINE_WORDS(LINE_WORDS), .SETS(SETS), .TAG_W(TW)
  ) u_array (
    .clk        (clk),
    .rst        (rst),
    .flush_i    (fence_i),
    .idx_i      (req_idx),
    .rd_word_i  (req_word),
    .rd_valid_o (arr_valid),
    .rd_tag_o   (arr_tag),
    .rd_data_o  (arr_data),
    .wr_en_i    (arr_we),
    .wr_word_i  (beat_q),
    .wr_data_i  (mem.rdata),
    .tag_we_i   (tag_we),
    .tag_valid_i(tag_valid),
    .tag_i      (req_tag)
  );

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      beat_q  <= '0;
      err_q   <= 1'b0;
      kill_q  <= 1'b0;
      rdata_q <= '0;
      rresp_q <= RESP_OKAY;
      hit_q   <= '0;
      miss_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      beat_q  <= beat_d;
      err_q   <= err_d;
      kill_q  <= kill_d;
      rdata_q <= rdata_d;
      rresp_q <= rresp_d;
      hit_q   <= hit_d;
      miss_q  <= miss_d;
    end
  end

  // Next-state and bus outputs.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    beat_d      = beat_q;
    err_d       = err_q;
    kill_d      = kill_q | (fence_i && (state_q == S_REF_AR || state_q == S_REF_R));
    rdata_d     = rdata_q;
    rresp_d     = rresp_q;
    hit_d       = hit_q;
    miss_d      = miss_q;
    arr_we      = 1'b0;
    tag_we      = 1'b0;
    tag_valid   = 1'b0;
    ifu.arready = 1'b0;
    ifu.rvalid  = 1'b0;
    ifu.rdata   = rdata_q;
    ifu.rresp   = rresp_q;
    mem.arvalid = 1'b0;
    mem.araddr  = '0;
    mem.rready  = 1'b0;
    case (state_q)
      S_IDLE: begin
        ifu.arready = 1'b1;
        if (ifu.arvalid) begin
          addr_d  = ifu.araddr[31:2];
          state_d = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        if (!cacheable) begin
          state_d = S_BYP_AR;
        end else if (hit) begin
          // Hit answers in this cycle; the register copy covers a stalled IFU.
          ifu.rvalid = 1'b1;
          ifu.rdata  = arr_data;
          ifu.rresp  = RESP_OKAY;
          rdata_d    = arr_data;
          rresp_d    = RESP_OKAY;
          hit_d      = sat_inc(hit_q);
          state_d    = ifu.rready ? S_IDLE : S_RESP;
        end else begin
          miss_d  = sat_inc(miss_q);
          beat_d  = '0;
          err_d   = 1'b0;
          kill_d  = 1'b0;
          state_d = S_REF_AR;
        end
      end
      S_REF_AR: begin
        mem.arvalid = 1'b1;
        mem.araddr  = {addr_q[31:2+WB], beat_q, 2'b00};
        if (mem.arready) state_d = S_REF_R;
      end
      S_REF_R: begin
        mem.rready = 1'b1;
        if (mem.rvalid) begin
          arr_we = 1'b1;
          err_d  = err_q | (mem.rresp != RESP_OKAY);
          if (beat_q == req_word) rdata_d = mem.rdata;
          if (last_beat) begin
            tag_we    = 1'b1;
            tag_valid = !err_d && !kill_d;
            rresp_d   = err_d ? RESP_SLVERR : RESP_OKAY;
            state_d   = S_RESP;
          end else begin
            beat_d  = beat_q + 1'b1;
            state_d = S_REF_AR;
          end
        end
      end
      S_BYP_AR: begin
        mem.arvalid = 1'b1;
        mem.araddr  = {addr_q, 2'b00};
        if (mem.arready) state_d = S_BYP_R;
      end
      S_BYP_R: begin
        mem.rready = 1'b1;
        if (mem.rvalid) begin
          rdata_d = mem.rdata;
          rresp_d = mem.rresp;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        ifu.rvalid = 1'b1;
        if (ifu.rready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_ysyx_25040129_icache.sv
// Directed bench for the instruction cache: IFU driver task, a memory responder that
// logs every accepted read address, and one task per scenario with inline checks.
module tb_ysyx_25040129_icache;
  import ysyx_25040129_icache_pkg::*;

  localparam int TMO = 200;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fence_i = 1'b0;
  logic [31:0] hit_cnt, miss_cnt;
  state_e      state_o;

  ysyx_25040129_icache_if ifu ();
  ysyx_25040129_icache_if mem ();

  ysyx_25040129_icache dut (
    .clk(clk), .rst(rst), .fence_i(fence_i), .ifu(ifu), .mem(mem),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt), .state_o(state_o)
  );

  // Clock and global time bound.
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int          n_vec = 0;
  int          n_err = 0;
  int          exp_hit = 0;
  int          exp_miss = 0;
  logic [31:0] ar_log [$];
  logic [31:0] exp_q [$];
  logic [31:0] err_addr = 32'h0;

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    if (a[31:4] == 28'h300_0000) return 32'h11 * ({30'd0, a[3:2]} + 32'd1);
    return a ^ 32'hDEAD_0000;
  endfunction

  // Memory responder: accepts an address, returns data the next cycle.
  initial begin : mem_model
    int          ph;
    logic [31:0] pend;
    ph = 0;
    pend = '0;
    mem.arready = 1'b1;
    mem.rvalid  = 1'b0;
    mem.rdata   = '0;
    mem.rresp   = RESP_OKAY;
    forever begin
      @(negedge clk);
      if (rst) begin
        ph = 0;
        mem.arready = 1'b1;
        mem.rvalid  = 1'b0;
      end else begin
        if (ph == 2) begin
          mem.rvalid  = 1'b0;
          mem.arready = 1'b1;
          ph = 0;
        end else if (ph == 1) begin
          mem.arready = 1'b0;
          mem.rvalid  = 1'b1;
          mem.rdata   = mem_data(pend);
          mem.rresp   = (pend == err_addr) ? RESP_SLVERR : RESP_OKAY;
          ph = 2;
        end
        if (ph == 0 && mem.arvalid === 1'b1) begin
          ar_log.push_back(mem.araddr);
          pend = mem.araddr;
          ph = 1;
        end
      end
    end
  end

  // IFU driver: one fetch; hold>0 keeps rready low that many cycles after rvalid.
  task automatic fetch(input logic [31:0] a, input int hold, output logic [31:0] d,
                       output logic [1:0] r, output int lat, output logic stable);
    @(negedge clk);
    ifu.araddr  = a;
    ifu.arvalid = 1'b1;
    ifu.rready  = (hold == 0);
    @(negedge clk);
    ifu.arvalid = 1'b0;
    lat = 0;
    stable = 1'b1;
    while (ifu.rvalid !== 1'b1 && lat < TMO) begin
      @(negedge clk);
      lat++;
    end
    d = ifu.rdata;
    r = ifu.rresp;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (ifu.rvalid !== 1'b1 || ifu.rdata !== d || ifu.rresp !== r) stable = 1'b0;
    end
    ifu.rready = 1'b1;
    @(negedge clk);
    ifu.rready = 1'b0;
  endtask

  task automatic test_reset();
    n_vec++;
    if ({ifu.arready, ifu.rvalid, ifu.rresp, mem.arvalid, mem.rready} !== 6'b100000) begin
      n_err++;
      $display("FAIL reset_ctrl: got %b want 100000",
               {ifu.arready, ifu.rvalid, ifu.rresp, mem.arvalid, mem.rready});
    end
    n_vec++;
    if ({ifu.rdata, mem.araddr, hit_cnt, miss_cnt} !== 128'd0) begin
      n_err++;
      $display("FAIL reset_data: rdata %h m_araddr %h hit %0d miss %0d want all 0",
               ifu.rdata, mem.araddr, hit_cnt, miss_cnt);
    end
    n_vec++;
    if (state_o !== S_IDLE) begin
      n_err++;
      $display("FAIL reset_state: got %0d want %0d", state_o, S_IDLE);
    end
  endtask

  task automatic test_cold_miss();
    logic [31:0] d; logic [1:0] r; int lat; logic st;
    ar_log.delete(); exp_q.delete();
    exp_q = '{32'h3000_0000, 32'h3000_0004, 32'h3000_0008, 32'h3000_000C};
    fetch(32'h3000_0000, 0, d, r, lat, st);
    exp_miss++;
    n_vec++;
    if (lat >= TMO) begin n_err++; $display("FAIL cold_timeout: lat %0d limit %0d", lat, TMO); end
    n_vec++;
    if (d !== 32'h11 || r !== RESP_OKAY) begin
      n_err++; $display("FAIL cold_resp: got %h/%b want 00000011/00", d, r);
    end
    n_vec++;
    if (ar_log.size() != exp_q.size()) begin
      n_err++; $display("FAIL cold_ar_count: got %0d want %0d", ar_log.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        n_vec++;
        if (ar_log[i] !== exp_q[i]) begin
          n_err++; $display("FAIL cold_ar%0d: got %h want %h", i, ar_log[i], exp_q[i]);
        end
      end
    end
    n_vec++;
    if (miss_cnt !== 32'(exp_miss) || hit_cnt !== 32'(exp_hit)) begin
      n_err++; $display("FAIL cold_cnt: hit %0d miss %0d want %0d %0d", hit_cnt, miss_cnt, exp_hit, exp_miss);
    end
  endtask

  task automatic test_hit();
    logic [31:0] d; logic [1:0] r; int lat; logic st;
    ar_log.delete();
    fetch(32'h3000_0008, 0, d, r, lat, st);
    exp_hit++;
    n_vec++;
    if (lat !== 0 || d !== 32'h33 || r !== RESP_OKAY) begin
      n_err++; $display("FAIL hit_word2: lat %0d data %h resp %b want 0 00000033 00", lat, d, r);
    end
    fetch(32'h3000_0003, 0, d, r, lat, st);
    exp_hit++;
    n_vec++;
    if (lat !== 0 || d !== 32'h11) begin
      n_err++; $display("FAIL hit_offset: lat %0d data %h want 0 00000011", lat, d);
    end
    n_vec++;
    if (ar_log.size() != 0) begin
      n_err++; $display("FAIL hit_no_mem: got %0d reads want 0", ar_log.size());
    end
    n_vec++;
    if (hit_cnt !== 32'(exp_hit) || miss_cnt !== 32'(exp_miss)) begin
      n_err++; $display("FAIL hit_cnt: hit %0d miss %0d want %0d %0d", hit_cnt, miss_cnt, exp_hit, exp_miss);
    end
  endtask

  task automatic test_evict();
    logic [31:0] d; logic [1:0] r; int lat; logic st;
    ar_log.delete();
    fetch(32'h3000_0100, 0, d, r, lat, st);
    exp_miss++;
    n_vec++;
    if (d !== 32'hEEAD_0100 || ar_log.size() != 4) begin
      n_err++; $display("FAIL evict_fill: data %h reads %0d want eead0100 4", d, ar_log.size());
    end
    n_vec++;
    if (ar_log.size() == 4 && ar_log[3] !== 32'h3000_010C) begin
      n_err++; $display("FAIL evict_last_addr: got %h want 3000010c", ar_log[3]);
    end
    ar_log.delete();
    fetch(32'h3000_0000, 0, d, r, lat, st);
    exp_miss++;
    n_vec++;
    if (d !== 32'h11 || ar_log.size() != 4) begin
      n_err++; $display("FAIL evict_refetch: data %h reads %0d want 00000011 4", d, ar_log.size());
    end
    n_vec++;
    if (hit_cnt !== 32'(exp_hit) || miss_cnt !== 32'(exp_miss)) begin
      n_err++; $display("FAIL evict_cnt: hit %0d miss %0d want %0d %0d", hit_cnt, miss_cnt, exp_hit, exp_miss);
    end
  endtask

  task automatic test_bypass();
    logic [31:0] d; logic [1:0] r; int lat; logic st;
    logic [31:0] addrs [3] = '{32'h8000_0000, 32'h8000_0006, 32'h4000_0000};
    logic [31:0] mads  [3] = '{32'h8000_0000, 32'h8000_0004, 32'h4000_0000};
    logic [31:0] datas [3] = '{32'h5EAD_0000, 32'h5EAD_0004, 32'h9EAD_0000};
    for (int i = 0; i < 3; i++) begin
      ar_log.delete();
      fetch(addrs[i], 0, d, r, lat, st);
      n_vec++;
      if (d !== datas[i] || r !== RESP_OKAY || ar_log.size() != 1) begin
        n_err++; $display("FAIL bypass%0d: data %h resp %b reads %0d want %h 00 1", i, d, r, ar_log.size(), datas[i]);
      end else begin
        n_vec++;
        if (ar_log[0] !== mads[i]) begin
          n_err++; $display("FAIL bypass%0d_addr: got %h want %h", i, ar_log[0], mads[i]);
        end
      end
    end
    n_vec++;
    if (hit_cnt !== 32'(exp_hit) || miss_cnt !== 32'(exp_miss)) begin
      n_err++; $display("FAIL bypass_cnt: hit %0d miss %0d want %0d %0d", hit_cnt, miss_cnt, exp_hit, exp_miss);
    end
  endtask

  task automatic test_fence();
    logic [31:0] d; logic [1:0] r; int lat; logic st;
    ar_log.delete();
    fork
      fetch(32'h3000_0024, 0, d, r, lat, st);
      begin
        int w = 0;
        while (ar_log.size() < 3 && w < TMO) begin @(negedge clk); w++; end
        fence_i = 1'b1;
        @(negedge clk);
        fence_i = 1'b0;
      end
    join
    exp_miss++;
    n_vec++;
    if (d !== 32'hEEAD_0024 || r !== RESP_OKAY) begin
      n_err++; $display("FAIL fence_data: got %h/%b want eead0024/00", d, r);
    end
    ar_log.delete();
    fetch(32'h3000_0000, 0, d, r, lat, st);
    exp_miss++;
    n_vec++;
    if (d !== 32'h11 || ar_log.size() != 4) begin
      n_err++; $display("FAIL fence_other_line: data %h reads %0d want 00000011 4", d, ar_log.size());
    end
    ar_log.delete();
    fetch(32'h3000_0020, 0, d, r, lat, st);
    exp_miss++;
    n_vec++;
    if (d !== 32'hEEAD_0020 || ar_log.size() != 4) begin
      n_err++; $display("FAIL fence_killed_line: data %h reads %0d want eead0020 4", d, ar_log.size());
    end
    fetch(32'h3000_0028, 0, d, r, lat, st);
    exp_hit++;
    n_vec++;
    if (lat !== 0 || d !== 32'hEEAD_0028) begin
      n_err++; $display("FAIL fence_rehit: lat %0d data %h want 0 eead0028", lat, d);
    end
    n_vec++;
    if (hit_cnt !== 32'(exp_hit) || miss_cnt !== 32'(exp_miss)) begin
      n_err++; $display("FAIL fence_cnt: hit %0d miss %0d want %0d %0d", hit_cnt, miss_cnt, exp_hit, exp_miss);
    end
  endtask

  task automatic test_error();
    logic [31:0] d; logic [1:0] r; int lat; logic st;
    err_addr = 32'h3000_0034;
    fetch(32'h3000_0030, 5, d, r, lat, st);
    exp_miss++;
    n_vec++;
    if (d !== 32'hEEAD_0030 || r !== RESP_SLVERR) begin
      n_err++; $display("FAIL err_resp: got %h/%b want eead0030/10", d, r);
    end
    n_vec++;
    if (st !== 1'b1) begin
      n_err++; $display("FAIL err_hold_stable: got %b want 1", st);
    end
    err_addr = 32'h0;
    ar_log.delete();
    fetch(32'h3000_0030, 0, d, r, lat, st);
    exp_miss++;
    n_vec++;
    if (ar_log.size() != 4 || r !== RESP_OKAY || d !== 32'hEEAD_0030) begin
      n_err++; $display("FAIL err_refetch: reads %0d resp %b data %h want 4 00 eead0030", ar_log.size(), r, d);
    end
    err_addr = 32'h8000_0010;
    fetch(32'h8000_0010, 0, d, r, lat, st);
    err_addr = 32'h0;
    n_vec++;
    if (d !== 32'h5EAD_0010 || r !== RESP_SLVERR) begin
      n_err++; $display("FAIL err_bypass: got %h/%b want 5ead0010/10", d, r);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d; logic [1:0] r; int lat; logic st;
    logic [31:0] addrs [3] = '{32'h3000_0030, 32'h3000_0034, 32'h3000_003C};
    logic [31:0] datas [3] = '{32'hEEAD_0030, 32'hEEAD_0034, 32'hEEAD_003C};
    ar_log.delete();
    for (int i = 0; i < 3; i++) begin
      fetch(addrs[i], (i == 0) ? 3 : 0, d, r, lat, st);
      exp_hit++;
      n_vec++;
      if (lat !== 0 || d !== datas[i] || r !== RESP_OKAY || st !== 1'b1) begin
        n_err++; $display("FAIL b2b%0d: lat %0d data %h resp %b stable %b want 0 %h 00 1", i, lat, d, r, st, datas[i]);
      end
    end
    n_vec++;
    if (ar_log.size() != 0 || hit_cnt !== 32'(exp_hit) || miss_cnt !== 32'(exp_miss)) begin
      n_err++; $display("FAIL b2b_cnt: reads %0d hit %0d miss %0d want 0 %0d %0d",
                        ar_log.size(), hit_cnt, miss_cnt, exp_hit, exp_miss);
    end
  endtask

  initial begin
    ifu.araddr  = '0;
    ifu.arvalid = 1'b0;
    ifu.rready  = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    test_reset();
    test_cold_miss();
    test_hit();
    test_evict();
    test_bypass();
    test_fence();
    test_error();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
